// File: rtl/eq_band_regbank.sv
// AXI4-Lite register bank for EQ band gains with shadow/active double buffering.
// Committed shadow gains move to the active bank only on a frame strobe.
module eq_band_regbank #(
    parameter int unsigned       NUM_BANDS  = 8,
    parameter int unsigned       COEF_W     = 18,
    parameter int unsigned       ADDR_W     = 9,
    parameter logic [COEF_W-1:0] RESET_GAIN = COEF_W'(1) << (COEF_W - 2)
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [ADDR_W-1:0]           S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [31:0]                 S_AXI_WDATA,
    input  logic [3:0]                  S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [ADDR_W-1:0]           S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [31:0]                 S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    input  logic                        frame_strobe,
    output logic [NUM_BANDS*COEF_W-1:0] gains_active,
    output logic                        bypass,
    output logic                        gains_updated
);

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RResp} r_state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [COEF_W-1:0] shadow_q [NUM_BANDS];
    logic [COEF_W-1:0] shadow_d [NUM_BANDS];
    logic [COEF_W-1:0] active_q [NUM_BANDS];
    logic [COEF_W-1:0] active_d [NUM_BANDS];
    logic              bypass_q, bypass_d;
    logic              pending_q, pending_d;
    logic [7:0]        count_q, count_d;
    logic              updated_q, updated_d;

    logic [31:0] aw_word, ar_word;
    logic        wr_fire, wr_err, commit, xfer;
    logic [31:0] rd_val;
    logic        rd_err;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_word = 32'(S_AXI_AWADDR[ADDR_W-1:2]);
    assign ar_word = 32'(S_AXI_ARADDR[ADDR_W-1:2]);

    // Untouched byte lanes keep the stored value; bits above COEF_W fall away.
    function automatic logic [COEF_W-1:0] merge_gain(input logic [COEF_W-1:0] old_val,
                                                     input logic [31:0]       data,
                                                     input logic [3:0]        strb);
        logic [31:0] res;
        res = 32'(old_val);
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res[COEF_W-1:0];
    endfunction

    assign wr_err = !((aw_word <= 32'd2) ||
                      ((aw_word >= 32'd4) && (aw_word < 32'(4 + NUM_BANDS))));

    always_comb begin
        w_state_d     = w_state_q;
        bresp_d       = bresp_q;
        wr_fire       = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                if (S_AXI_AWVALID && S_AXI_WVALID && !ARESET) begin
                    wr_fire   = 1'b1;
                    w_state_d = WResp;
                    bresp_d   = wr_err ? RespSlverr : RespOkay;
                end
            end
            WResp: begin
                if (S_AXI_BREADY) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
        S_AXI_AWREADY = wr_fire;
        S_AXI_WREADY  = wr_fire;
    end

    always_comb begin
        rd_val = 32'd0;
        rd_err = 1'b0;
        if (ar_word == 32'd0) begin
            rd_val = {30'd0, bypass_q, 1'b0};
        end else if (ar_word == 32'd1) begin
            rd_val = {16'd0, count_q, 7'd0, pending_q};
        end else if (ar_word == 32'd2) begin
            rd_val = {16'd0, 8'(COEF_W), 8'(NUM_BANDS)};
        end else if ((ar_word >= 32'd4) && (ar_word < 32'(4 + NUM_BANDS))) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                if (ar_word == 32'(4 + k)) rd_val = 32'($signed(shadow_q[k]));
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    always_comb begin
        r_state_d     = r_state_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        S_AXI_ARREADY = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                if (S_AXI_ARVALID && !ARESET) begin
                    S_AXI_ARREADY = 1'b1;
                    r_state_d     = RResp;
                    rdata_d       = rd_val;
                    rresp_d       = rd_err ? RespSlverr : RespOkay;
                end
            end
            RResp: begin
                if (S_AXI_RREADY) r_state_d = RIdle;
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Transfer uses pre-edge shadow and PENDING; a same-cycle COMMIT re-arms afterwards.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        bypass_d  = bypass_q;
        count_d   = count_q;
        updated_d = 1'b0;
        commit    = 1'b0;
        xfer      = frame_strobe && pending_q;
        if (xfer) begin
            active_d  = shadow_q;
            count_d   = count_q + 8'd1;
            updated_d = 1'b1;
        end
        if (wr_fire) begin
            if ((aw_word == 32'd0) && S_AXI_WSTRB[0]) begin
                bypass_d = S_AXI_WDATA[1];
                commit   = S_AXI_WDATA[0];
            end
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                if (aw_word == 32'(4 + k)) begin
                    shadow_d[k] = merge_gain(shadow_q[k], S_AXI_WDATA, S_AXI_WSTRB);
                end
            end
        end
        if (commit)    pending_d = 1'b1;
        else if (xfer) pending_d = 1'b0;
        else           pending_d = pending_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            bresp_q   <= RespOkay;
            rresp_q   <= RespOkay;
            rdata_q   <= 32'd0;
            bypass_q  <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= 8'd0;
            updated_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                shadow_q[k] <= RESET_GAIN;
                active_q[k] <= RESET_GAIN;
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            bypass_q  <= bypass_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            updated_q <= updated_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_pack
        assign gains_active[g*COEF_W +: COEF_W] = active_q[g];
    end

    assign S_AXI_BVALID  = (w_state_q == WResp);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (r_state_q == RResp);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign bypass        = bypass_q;
    assign gains_updated = updated_q;

endmodule

// File: tb/tb_eq_band_regbank.sv
// Randomised bench for eq_band_regbank against an array-based register model.
module tb_eq_band_regbank;

    localparam int NB = 8;
    localparam int CW = 18;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [8:0]   S_AXI_AWADDR = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [8:0]   S_AXI_ARADDR = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic         frame_strobe = 1'b0;
    logic [NB*CW-1:0] gains_active;
    logic         bypass;
    logic         gains_updated;

    eq_band_regbank dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA),
        .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA),
        .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .frame_strobe(frame_strobe),
        .gains_active(gains_active), .bypass(bypass), .gains_updated(gains_updated)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_shadow [NB];
    logic [31:0] m_active [NB];
    bit          m_bypass;
    bit          m_pending;
    int          m_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_shadow[k] = 32'h10000;
            m_active[k] = 32'h10000;
        end
        m_bypass  = 0;
        m_pending = 0;
        m_count   = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = 0;
        for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
        return ((old_v & ~m) | (data & m)) & 32'h3FFFF;
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v);
        return v[17] ? (v | 32'hFFFC0000) : v;
    endfunction

    task automatic model_xfer(output bit x);
        x = m_pending;
        if (x) begin
            for (int k = 0; k < NB; k++) m_active[k] = m_shadow[k];
            m_pending = 0;
            m_count   = (m_count + 1) % 256;
        end
    endtask

    task automatic model_write(input logic [8:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int w;
        w = int'(addr) / 4;
        resp = 2'b00;
        if (w == 0) begin
            if (strb[0]) begin
                m_bypass = data[1];
                if (data[0]) m_pending = 1;
            end
        end else if (w == 1 || w == 2) begin
            resp = 2'b00;
        end else if (w >= 4 && w < 4 + NB) begin
            m_shadow[w-4] = merge(m_shadow[w-4], data, strb);
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [8:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int w;
        w = int'(addr) / 4;
        resp = 2'b00;
        data = 0;
        if (w == 0)                      data = m_bypass ? 32'h2 : 32'h0;
        else if (w == 1)                 data = 32'(m_count * 256 + (m_pending ? 1 : 0));
        else if (w == 2)                 data = 32'(CW * 256 + NB);
        else if (w >= 4 && w < 4 + NB)   data = sext(m_shadow[w-4]);
        else                             resp = 2'b10;
    endtask

    task automatic check_active(input string tag);
        for (int k = 0; k < NB; k++)
            check_eq($sformatf("%s_b%0d", tag, k), 32'(gains_active[k*CW +: CW]), m_active[k]);
    endtask

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit strobe);
        bit acc;
        bit x;
        logic [1:0] eresp;
        acc = 0;
        x = 0;
        eresp = 2'b00;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA = data;
        S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        S_AXI_BREADY = 1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (S_AXI_AWREADY && S_AXI_WREADY) begin
                acc = 1;
                frame_strobe = strobe;
                if (strobe) model_xfer(x);
                model_write(addr, data, strb, eresp);
                tick();
                break;
            end
            tick();
        end
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        frame_strobe = 0;
        check_eq("aw_accept", 32'(acc), 32'd1);
        if (acc) begin
            if (strobe) begin
                check_eq("upd_on_write", 32'(gains_updated), 32'(x));
                check_active("act_on_write");
            end
            check_eq("bvalid", 32'(S_AXI_BVALID), 32'd1);
            check_eq("bresp", 32'(S_AXI_BRESP), 32'(eresp));
            tick();
        end
        S_AXI_BREADY = 0;
        check_eq("bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [8:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit acc;
        acc = 0;
        data = 32'hDEADBEEF;
        resp = 2'b11;
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1;
        S_AXI_RREADY = 1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (S_AXI_ARREADY) begin
                acc = 1;
                tick();
                break;
            end
            tick();
        end
        S_AXI_ARVALID = 0;
        check_eq("ar_accept", 32'(acc), 32'd1);
        if (acc) begin
            check_eq("rvalid", 32'(S_AXI_RVALID), 32'd1);
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
            tick();
        end
        S_AXI_RREADY = 0;
        check_eq("rvalid_clr", 32'(S_AXI_RVALID), 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [8:0] addr);
        logic [31:0] ed, d;
        logic [1:0]  er, r;
        model_read(addr, ed, er);
        axi_read(addr, d, r);
        check_eq({tag, "_data"}, d, ed);
        check_eq({tag, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic frame_pulse();
        bit x;
        frame_strobe = 1;
        model_xfer(x);
        tick();
        frame_strobe = 0;
        check_eq("upd_pulse", 32'(gains_updated), 32'(x));
        check_active("act_frame");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          op;
        int          k;
        model_reset();
        repeat (3) tick();
        ARESET = 0;

        // Reset state
        check_eq("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check_eq("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check_eq("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
        check_eq("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        check_eq("rst_rdata", S_AXI_RDATA, 32'd0);
        check_eq("rst_bypass", 32'(bypass), 32'd0);
        check_eq("rst_upd", 32'(gains_updated), 32'd0);
        check_active("rst_act");
        axi_read(9'h008, d, r);
        check_eq("info", d, 32'h00001208);
        check_eq("info_resp", 32'(r), 32'd0);
        axi_read(9'h01C, d, r);
        check_eq("gain3_rst", d, 32'h00010000);

        // Shadow write without commit, then commit and transfer
        axi_write(9'h018, 32'h00012345, 4'hF, 0);
        repeat (3) frame_pulse();
        check_eq("b2_hold", 32'(gains_active[2*CW +: CW]), 32'h10000);
        axi_write(9'h000, 32'h1, 4'h1, 0);
        axi_read(9'h004, d, r);
        check_eq("status_pend", d, 32'h00000001);
        frame_pulse();
        check_eq("b2_new", 32'(gains_active[2*CW +: CW]), 32'h12345);
        check_eq("upd_once", 32'(gains_updated), 32'd1);
        tick();
        check_eq("upd_drop", 32'(gains_updated), 32'd0);
        axi_read(9'h004, d, r);
        check_eq("status_cnt", d, 32'h00000100);

        // Partial strobe
        axi_write(9'h010, 32'hFFFFFFAA, 4'b0001, 0);
        axi_read(9'h010, d, r);
        check_eq("strb_merge", d, 32'h000100AA);

        // Out-of-map access
        axi_write(9'h030, 32'h12345678, 4'hF, 0);
        axi_read(9'h030, d, r);
        check_eq("bad_rdata", d, 32'd0);
        check_eq("bad_rresp", 32'(r), 32'd2);
        read_chk("bad_g0", 9'h010);

        // Commit and strobe in the same cycle, both with and without a prior commit
        axi_write(9'h014, 32'h0002AAAA, 4'hF, 0);
        axi_write(9'h000, 32'h1, 4'h1, 1);
        read_chk("same_p0", 9'h004);
        axi_write(9'h000, 32'h1, 4'h1, 1);
        read_chk("same_p1", 9'h004);
        axi_write(9'h020, 32'h00015555, 4'hF, 1);
        read_chk("same_gw", 9'h020);

        // Backpressure on B with a second write waiting
        S_AXI_AWADDR = 9'h014;
        S_AXI_WDATA = 32'h00003333;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        S_AXI_BREADY = 0;
        #2;
        check_eq("bp_aw_acc", 32'(S_AXI_AWREADY), 32'd1);
        model_write(9'h014, 32'h00003333, 4'hF, r);
        tick();
        S_AXI_AWADDR = 9'h024;
        S_AXI_WDATA = 32'h00004444;
        for (int i = 0; i < 10; i++) begin
            #2;
            check_eq("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
            check_eq("bp_bvalid", 32'(S_AXI_BVALID), 32'd1);
            check_eq("bp_bresp", 32'(S_AXI_BRESP), 32'd0);
            tick();
        end
        read_chk("bp_g5_untouched", 9'h024);
        S_AXI_BREADY = 1;
        tick();
        axi_write(9'h024, 32'h00004444, 4'hF, 0);
        read_chk("bp_g5", 9'h024);

        // Backpressure on R
        model_read(9'h014, d, r);
        S_AXI_ARADDR = 9'h014;
        S_AXI_ARVALID = 1;
        S_AXI_RREADY = 0;
        #2;
        check_eq("bpr_ar_acc", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 0;
        for (int i = 0; i < 10; i++) begin
            check_eq("bpr_rvalid", 32'(S_AXI_RVALID), 32'd1);
            check_eq("bpr_rdata", S_AXI_RDATA, d);
            tick();
        end
        S_AXI_RREADY = 1;
        tick();
        S_AXI_RREADY = 0;
        check_eq("bpr_rclr", 32'(S_AXI_RVALID), 32'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            k = $urandom_range(0, NB - 1);
            if (op <= 3) begin
                axi_write(9'(16 + 4 * k + $urandom_range(0, 3)), $urandom,
                          4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
            end else if (op == 4) begin
                axi_write(9'h000, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1);
                check_eq("rnd_bypass", 32'(bypass), 32'(m_bypass));
            end else if (op <= 6) begin
                read_chk("rnd_rd", 9'(4 * $urandom_range(0, 13) + $urandom_range(0, 3)));
            end else if (op <= 8) begin
                frame_pulse();
            end else begin
                axi_write(9'(4 * $urandom_range(0, 127)), $urandom, 4'hF, 0);
            end
        end

        // Reset during a held write response with a commit pending
        axi_write(9'h000, 32'h1, 4'h1, 0);
        S_AXI_AWADDR = 9'h024;
        S_AXI_WDATA = 32'h00007777;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        S_AXI_BREADY = 0;
        #2;
        check_eq("rst_w_acc", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        check_eq("rst_w_bvalid", 32'(S_AXI_BVALID), 32'd1);
        ARESET = 1;
        tick();
        model_reset();
        check_eq("rst_mid_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check_active("rst_mid_act");
        ARESET = 0;
        read_chk("rst_mid_status", 9'h004);
        read_chk("rst_mid_g5", 9'h024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
